// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: stall-controller states, register-zero constant
// and the ID control fields that a bubble clears.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } stall_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic cache_en;
        logic jump;
        logic halted;
    } id_ctrl_t;

    // Every field with a side effect must be listed here, or a bubble could leak it.
    localparam id_ctrl_t BUBBLE_CLEAR = '{
        reg_write: 1'b1,
        mem_write: 1'b1,
        cache_en:  1'b1,
        jump:      1'b1,
        halted:    1'b1
    };

    function automatic id_ctrl_t apply_bubble(input id_ctrl_t ctrl, input logic bubble);
        return bubble ? id_ctrl_t'(ctrl & ~BUBBLE_CLEAR) : ctrl;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Combinational load-use detector: flags an ID source that depends on a load
// still in EXE. Shared with the forwarding unit.
module load_use_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic [4:0] id_rs_num_i,
    input  logic [4:0] id_rt_num_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] exe_dest_reg_num_i,
    input  logic       exe_reg_write_i,
    input  logic       exe_mem_to_reg_i,
    output logic       lu_o
);

    logic load_in_exe;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        load_in_exe = exe_mem_to_reg_i & exe_reg_write_i & (exe_dest_reg_num_i != REG_ZERO);
        rs_hit      = id_uses_rs_i & (id_rs_num_i == exe_dest_reg_num_i);
        rt_hit      = id_uses_rt_i & (id_rt_num_i == exe_dest_reg_num_i);
        lu_o        = load_in_exe & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall controller: load-use bubbles, cache-miss full freeze, halt
// parking, plus a saturating stall counter and sticky cache-timeout flag.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       id_rs_num,
    input  logic [4:0]       id_rt_num,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       exe_dest_reg_num,
    input  logic             exe_reg_write,
    input  logic             exe_mem_to_reg,
    input  logic             mem_cache_req,
    input  logic             cache_ready,
    input  logic             wb_halted,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_exe_freeze,
    output logic             exe_mem_freeze,
    output logic             id_exe_bubble,
    output logic             halt_done,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    // Wide enough to represent MAX_WAIT + 1, so "exceeded" is observable before saturating.
    localparam int unsigned       WAIT_W     = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    stall_state_e      state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_d;

    logic lu;
    logic miss;
    logic full_freeze;
    logic lu_stall;
    logic halted;

    load_use_detect u_load_use_detect (
        .id_rs_num_i        (id_rs_num),
        .id_rt_num_i        (id_rt_num),
        .id_uses_rs_i       (id_uses_rs),
        .id_uses_rt_i       (id_uses_rt),
        .exe_dest_reg_num_i (exe_dest_reg_num),
        .exe_reg_write_i    (exe_reg_write),
        .exe_mem_to_reg_i   (exe_mem_to_reg),
        .lu_o               (lu)
    );

    always_comb begin
        miss        = mem_cache_req & ~cache_ready;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        full_freeze = 1'b0;
        lu_stall    = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (wb_halted) begin
                    full_freeze = 1'b1;
                    state_d     = HALT;
                end else if (miss) begin
                    full_freeze = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else if (lu) begin
                    lu_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cache_ready) begin
                    state_d = RUN;
                end else begin
                    full_freeze = 1'b1;
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            HALT: begin
                full_freeze = 1'b1;
                halted      = 1'b1;
            end
            default: state_d = RUN;
        endcase

        timeout_d = timeout_q | (wait_cnt_d > WAIT_LIMIT);

        stall_cnt_d = stall_cnt_q;
        if ((full_freeze | lu_stall) && (state_q != HALT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Gating with rst_b drops the Mealy outputs the moment reset is asserted.
    always_comb begin
        pc_freeze      = rst_b & (full_freeze | lu_stall);
        if_id_freeze   = rst_b & (full_freeze | lu_stall);
        id_exe_freeze  = rst_b & full_freeze;
        exe_mem_freeze = rst_b & full_freeze;
        id_exe_bubble  = rst_b & lu_stall;
        halt_done      = rst_b & halted;
        stall_count    = stall_cnt_q;
        timeout_err    = timeout_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_hazard_stall_unit;

    localparam int unsigned TB_CNT_W    = 4;
    localparam int unsigned TB_MAX_WAIT = 4;
    localparam int          STALL_MAX   = 15;

    logic       clk;
    logic       rst_b;
    logic [4:0] id_rs_num, id_rt_num, exe_dest_reg_num;
    logic       id_uses_rs, id_uses_rt, exe_reg_write, exe_mem_to_reg;
    logic       mem_cache_req, cache_ready, wb_halted;
    logic       pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze;
    logic       id_exe_bubble, halt_done, timeout_err;
    logic [TB_CNT_W-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_stall_unit #(
        .CNT_W    (TB_CNT_W),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .id_rs_num        (id_rs_num),
        .id_rt_num        (id_rt_num),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .exe_dest_reg_num (exe_dest_reg_num),
        .exe_reg_write    (exe_reg_write),
        .exe_mem_to_reg   (exe_mem_to_reg),
        .mem_cache_req    (mem_cache_req),
        .cache_ready      (cache_ready),
        .wb_halted        (wb_halted),
        .pc_freeze        (pc_freeze),
        .if_id_freeze     (if_id_freeze),
        .id_exe_freeze    (id_exe_freeze),
        .exe_mem_freeze   (exe_mem_freeze),
        .id_exe_bubble    (id_exe_bubble),
        .halt_done        (halt_done),
        .stall_count      (stall_count),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic m_halt, m_wait, m_tout;
    int   m_wl, m_stall;
    logic e_full, e_lu, e_halt;

    function automatic logic lu_now();
        logic load_dep;
        load_dep = exe_mem_to_reg && exe_reg_write && (exe_dest_reg_num != 5'd0);
        return load_dep && ((id_uses_rs && id_rs_num == exe_dest_reg_num) ||
                            (id_uses_rt && id_rt_num == exe_dest_reg_num));
    endfunction

    function automatic int sat_inc(input int v);
        return (v < STALL_MAX) ? v + 1 : STALL_MAX;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_halt  <= 1'b0;
            m_wait  <= 1'b0;
            m_tout  <= 1'b0;
            m_wl    <= 0;
            m_stall <= 0;
        end else if (!m_halt) begin
            if (m_wait) begin
                if (cache_ready) begin
                    m_wait <= 1'b0;
                end else begin
                    m_wl    <= m_wl + 1;
                    m_stall <= sat_inc(m_stall);
                    if (m_wl + 1 > int'(TB_MAX_WAIT)) m_tout <= 1'b1;
                end
            end else if (wb_halted) begin
                m_halt  <= 1'b1;
                m_stall <= sat_inc(m_stall);
            end else if (mem_cache_req && !cache_ready) begin
                m_wait  <= 1'b1;
                m_wl    <= 1;
                m_stall <= sat_inc(m_stall);
            end else if (lu_now()) begin
                m_stall <= sat_inc(m_stall);
            end
        end
    end

    always @(negedge clk) begin
        e_full = 1'b0;
        e_lu   = 1'b0;
        e_halt = 1'b0;
        if (rst_b) begin
            if (m_halt) begin
                e_full = 1'b1;
                e_halt = 1'b1;
            end else if (m_wait) begin
                e_full = !cache_ready;
            end else if (wb_halted || (mem_cache_req && !cache_ready)) begin
                e_full = 1'b1;
            end else begin
                e_lu = lu_now();
            end
        end
        check("m_pc_freeze",      32'(pc_freeze),      32'(e_full | e_lu));
        check("m_if_id_freeze",   32'(if_id_freeze),   32'(e_full | e_lu));
        check("m_id_exe_freeze",  32'(id_exe_freeze),  32'(e_full));
        check("m_exe_mem_freeze", 32'(exe_mem_freeze), 32'(e_full));
        check("m_id_exe_bubble",  32'(id_exe_bubble),  32'(e_lu));
        check("m_halt_done",      32'(halt_done),      32'(e_halt));
        check("m_stall_count",    32'(stall_count),    32'(m_stall));
        check("m_timeout_err",    32'(timeout_err),    32'(m_tout));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs_num = '0; id_rt_num = '0; exe_dest_reg_num = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        exe_reg_write = 1'b0; exe_mem_to_reg = 1'b0;
        mem_cache_req = 1'b0; cache_ready = 1'b0; wb_halted = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] dest, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic mtr, input logic rw);
        exe_dest_reg_num = dest; id_rs_num = rs; id_uses_rs = urs;
        id_rt_num = rt; id_uses_rt = urt; exe_mem_to_reg = mtr; exe_reg_write = rw;
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check({tag, "_pc"},     32'(pc_freeze),      32'(exp[5]));
        check({tag, "_ifid"},   32'(if_id_freeze),   32'(exp[4]));
        check({tag, "_idexe"},  32'(id_exe_freeze),  32'(exp[3]));
        check({tag, "_exemem"}, 32'(exe_mem_freeze), 32'(exp[2]));
        check({tag, "_bubble"}, 32'(id_exe_bubble),  32'(exp[1]));
        check({tag, "_halt"},   32'(halt_done),      32'(exp[0]));
    endtask

    typedef struct {
        logic [4:0] dest, rs, rt;
        logic urs, urt, mtr, rw, exp_lu;
    } lu_vec_t;

    lu_vec_t lu_tab[7] = '{
        '{dest:5'd5,  rs:5'd5, rt:5'd0,  urs:1'b1, urt:1'b0, mtr:1'b1, rw:1'b1, exp_lu:1'b1},
        '{dest:5'd0,  rs:5'd0, rt:5'd0,  urs:1'b1, urt:1'b0, mtr:1'b1, rw:1'b1, exp_lu:1'b0},
        '{dest:5'd7,  rs:5'd0, rt:5'd7,  urs:1'b0, urt:1'b1, mtr:1'b1, rw:1'b1, exp_lu:1'b1},
        '{dest:5'd7,  rs:5'd0, rt:5'd7,  urs:1'b0, urt:1'b0, mtr:1'b1, rw:1'b1, exp_lu:1'b0},
        '{dest:5'd9,  rs:5'd9, rt:5'd9,  urs:1'b1, urt:1'b1, mtr:1'b0, rw:1'b1, exp_lu:1'b0},
        '{dest:5'd9,  rs:5'd9, rt:5'd9,  urs:1'b1, urt:1'b1, mtr:1'b1, rw:1'b0, exp_lu:1'b0},
        '{dest:5'd31, rs:5'd3, rt:5'd31, urs:1'b1, urt:1'b1, mtr:1'b1, rw:1'b1, exp_lu:1'b1}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b1;
        id_rs_num = '1; id_rt_num = '1; exe_dest_reg_num = '1;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; exe_reg_write = 1'b1; exe_mem_to_reg = 1'b1;
        mem_cache_req = 1'b1; cache_ready = 1'b1; wb_halted = 1'b1;
        #1 rst_b = 1'b0;
        #2;
        check_ctl("rst_all_ones", 6'b000000);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        step();
        step();
        idle();
        rst_b = 1'b1;
        #2;
        check_ctl("post_rst", 6'b000000);
        check("post_rst_stall", 32'(stall_count), 32'd0);

        // Load-use table: one hazard cycle, then the load advances.
        foreach (lu_tab[i]) begin
            step();
            set_lu(lu_tab[i].dest, lu_tab[i].rs, lu_tab[i].urs, lu_tab[i].rt,
                   lu_tab[i].urt, lu_tab[i].mtr, lu_tab[i].rw);
            #2;
            check_ctl("lu_vec", lu_tab[i].exp_lu ? 6'b110010 : 6'b000000);
            step();
            idle();
        end
        #2;
        check("lu_stall_count", 32'(stall_count), 32'd3);

        // Miss: ready rises in the 4th cycle -> 3 stall cycles.
        step();
        mem_cache_req = 1'b1; cache_ready = 1'b0;
        #2 check_ctl("miss_c1", 6'b111100);
        step(); #2 check_ctl("miss_c2", 6'b111100);
        step(); #2 check_ctl("miss_c3", 6'b111100);
        step();
        cache_ready = 1'b1;
        #2 check_ctl("miss_ready", 6'b000000);
        step();
        idle();
        #2 check("miss_stall_count", 32'(stall_count), 32'd6);

        // Miss and load-use together: miss wins, bubble follows after ready.
        step();
        mem_cache_req = 1'b1; cache_ready = 1'b0;
        set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        #2 check_ctl("miss_lu_c1", 6'b111100);
        step();
        cache_ready = 1'b1;
        #2 check_ctl("miss_lu_ready", 6'b000000);
        step();
        mem_cache_req = 1'b0; cache_ready = 1'b0;
        #2 check_ctl("miss_lu_bubble", 6'b110010);
        step();
        idle();
        #2 check("miss_lu_stall_count", 32'(stall_count), 32'd8);

        // Timeout: 10 cycles without ready, flag visible from the 6th cycle.
        step();
        mem_cache_req = 1'b1; cache_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #2;
            if (i == 5) check("timeout_c5", 32'(timeout_err), 32'd0);
            if (i == 6) check("timeout_c6", 32'(timeout_err), 32'd1);
            step();
        end
        cache_ready = 1'b1;
        #2;
        check_ctl("timeout_ready", 6'b000000);
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        check("stall_saturated", 32'(stall_count), 32'd15);
        step();
        idle();
        #2 check("timeout_held", 32'(timeout_err), 32'd1);
        step();
        rst_b = 1'b0;
        #2;
        check("timeout_cleared", 32'(timeout_err), 32'd0);
        check("stall_cleared", 32'(stall_count), 32'd0);
        rst_b = 1'b1;

        // Halt beats a simultaneous miss; HALT is terminal and not counted.
        step();
        wb_halted = 1'b1; mem_cache_req = 1'b1; cache_ready = 1'b0;
        #2 check_ctl("halt_seen", 6'b111100);
        step();
        idle();
        set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #2;
            check_ctl("halted", 6'b111101);
            check("halt_stall_frozen", 32'(stall_count), 32'd1);
            step();
        end
        #1 rst_b = 1'b0;
        #1 check_ctl("halt_async_rst", 6'b000000);
        step();
        idle();
        rst_b = 1'b1;
        step();
        #2;
        check_ctl("after_halt_rst", 6'b000000);
        check("after_halt_stall", 32'(stall_count), 32'd0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
